est_atmos_light: RTL

Atmospheric-light estimator that produces the `A_r/A_g/A_b` + `A_valid` interface consumed by the saturation stage. It scans each input frame's pixel stream and picks the brightest dark-channel pixel as the frame's candidate. At end of frame it applies temporal IIR smoothing and a floor clamp, then publishes the new A. A stays constant for the whole of the following frame, so the downstream inverse-A LUTs see stable operands.

---
 rtl/dehaze_pkg.sv | 30 +++
 rtl/dark_min3.sv | 16 +
 rtl/est_atmos_light.sv | 116 +++++++++++
 3 files changed

// File: rtl/dehaze_pkg.sv
// dehaze_pkg: shared pixel type, A defaults, estimator FSM states and the IIR/clamp helper
package dehaze_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pix_t;

   localparam logic [7:0] A_INIT_DEF = 8'd255;
   localparam logic [7:0] A_MIN_DEF  = 8'd64;

   typedef enum logic [1:0] {IDLE, SCAN, UPDATE} al_state_t;

   // One A channel: IIR step toward the candidate (or direct load when unprimed), floored at a_min.
   // The shift is arithmetic, so negative steps round toward minus infinity.
   function automatic logic [7:0] iir_clamp(input logic [7:0] a_old, input logic [7:0] cand,
                                            input logic primed, input int unsigned sh,
                                            input logic [7:0] a_min);
      logic signed [8:0] diff;
      logic signed [9:0] step;
      logic signed [9:0] a_new;
      diff  = $signed({1'b0, cand}) - $signed({1'b0, a_old});
      step  = $signed({diff[8], diff}) >>> sh;
      a_new = primed ? $signed({2'b0, a_old}) + step : $signed({2'b0, cand});
      return (a_new < $signed({2'b0, a_min})) ? a_min :
             (a_new > 10'sd255) ? 8'd255 : a_new[7:0];
   endfunction

endpackage

// File: rtl/dark_min3.sv
// dark_min3: dark channel (min of r,g,b) and 10-bit brightness sum of one pixel
module dark_min3
   import dehaze_pkg::*;
(
   input  pix_t       pix,
   output logic [7:0] dark,
   output logic [9:0] sum
);

   logic [7:0] rg;

   assign rg   = (pix.r < pix.g) ? pix.r : pix.g;
   assign dark = (rg < pix.b) ? rg : pix.b;
   assign sum  = 10'(pix.r) + 10'(pix.g) + 10'(pix.b);

endmodule

// File: rtl/est_atmos_light.sv
// est_atmos_light: per-frame brightest dark-channel pick, smoothed and floored into a stable A
module est_atmos_light
   import dehaze_pkg::*;
#(
   parameter int unsigned ALPHA_SH = 3,
   parameter logic [7:0]  A_MIN    = A_MIN_DEF,
   parameter logic [7:0]  A_INIT   = A_INIT_DEF
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_r,
   input  logic [7:0] in_g,
   input  logic [7:0] in_b,
   input  logic       in_valid,
   input  logic       in_sof,
   input  logic       in_eof,
   output logic [7:0] A_r,
   output logic [7:0] A_g,
   output logic [7:0] A_b,
   output logic       A_valid
);

   pix_t       in_pix, s1_pix, cand_pix, snap_pix;
   logic [7:0] in_dark, s1_dark, cand_dark;
   logic [9:0] in_sum, s1_sum, cand_sum;
   logic       s1_valid, s1_sof, s1_eof;
   logic       take, snap_we, primed;
   al_state_t  state, state_nxt;

   assign in_pix = {in_r, in_g, in_b};

   dark_min3 u_dark (
      .pix  (in_pix),
      .dark (in_dark),
      .sum  (in_sum)
   );

   // Stage 1: capture the pixel with its dark value, sum and frame flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_pix   <= '0;
         s1_dark  <= '0;
         s1_sum   <= '0;
         s1_sof   <= 1'b0;
         s1_eof   <= 1'b0;
      end else begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_pix  <= in_pix;
            s1_dark <= in_dark;
            s1_sum  <= in_sum;
            s1_sof  <= in_sof;
            s1_eof  <= in_eof;
         end
      end
   end

   // Strictly-greater compares keep the earliest pixel on an exact tie; sof always restarts
   assign take    = s1_sof || (s1_dark > cand_dark) || (s1_dark == cand_dark && s1_sum > cand_sum);
   assign snap_we = s1_valid && s1_eof && (state == SCAN || s1_sof);

   // Stage 2: running candidate and the end-of-frame snapshot (includes the eof pixel itself)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand_pix  <= '0;
         cand_dark <= '0;
         cand_sum  <= '0;
         snap_pix  <= '0;
      end else begin
         if (s1_valid && take) begin
            cand_pix  <= s1_pix;
            cand_dark <= s1_dark;
            cand_sum  <= s1_sum;
         end
         if (snap_we)
            snap_pix <= take ? s1_pix : cand_pix;
      end
   end

   // FSM next state: a snapshot forces UPDATE; a sof reaching stage 2 (even during UPDATE) means SCAN
   always_comb begin
      state_nxt = state;
      state_nxt = snap_we ? UPDATE :
                  (s1_valid && s1_sof) ? SCAN :
                  (state == UPDATE) ? IDLE : state;
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Publish A once per UPDATE cycle; it holds for the whole following frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         A_r     <= A_INIT;
         A_g     <= A_INIT;
         A_b     <= A_INIT;
         A_valid <= 1'b0;
         primed  <= 1'b0;
      end else begin
         A_valid <= (state == UPDATE);
         if (state == UPDATE) begin
            A_r    <= iir_clamp(A_r, snap_pix.r, primed, ALPHA_SH, A_MIN);
            A_g    <= iir_clamp(A_g, snap_pix.g, primed, ALPHA_SH, A_MIN);
            A_b    <= iir_clamp(A_b, snap_pix.b, primed, ALPHA_SH, A_MIN);
            primed <= 1'b1;
         end
      end
   end

endmodule
